// File: rtl/frog_hop_keycode_gen.sv
// rtl/frog_hop_keycode_gen.sv - turns raw WASD keycodes into fixed-length, one-per-press hops
// Each accepted press drives its direction for HOP_FRAMES frames, then forces a stop until the key changes.

module frog_hop_keycode_gen #(
   parameter int HOP_FRAMES      = 4,
   parameter int COOLDOWN_FRAMES = 2
) (
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic        enable,
   input  logic [15:0] raw_keycode,
   output logic [15:0] keycode,
   output logic        hop_active,
   output logic [7:0]  fwd_hops
);

   localparam logic [15:0] KEY_W = 16'h001A;
   localparam logic [15:0] KEY_A = 16'h0004;
   localparam logic [15:0] KEY_S = 16'h0016;
   localparam logic [15:0] KEY_D = 16'h0007;

   localparam logic [7:0] HOP_LAST  = 8'(HOP_FRAMES - 1);
   localparam logic [7:0] COOL_LAST = 8'(COOLDOWN_FRAMES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HOP      = 2'd1,
      COOL     = 2'd2,
      WAIT_REL = 2'd3
   } state_t;

   state_t      state, state_n;
   logic [15:0] dir, dir_n;
   logic [7:0]  cnt, cnt_n;
   logic [15:0] keycode_n;
   logic [7:0]  fwd_hops_n;
   logic        raw_valid;

   assign raw_valid = (raw_keycode == KEY_W) || (raw_keycode == KEY_A) ||
                      (raw_keycode == KEY_S) || (raw_keycode == KEY_D);

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         dir      <= 16'h0000;
         cnt      <= 8'd0;
         keycode  <= 16'h0000;
         fwd_hops <= 8'd0;
      end else begin
         state    <= state_n;
         dir      <= dir_n;
         cnt      <= cnt_n;
         keycode  <= keycode_n;
         fwd_hops <= fwd_hops_n;
      end
   end

   // Disable has priority so an aborted hop never reaches the fwd_hops update.
   always_comb begin
      state_n    = state;
      dir_n      = dir;
      cnt_n      = cnt;
      keycode_n  = 16'h0000;
      fwd_hops_n = fwd_hops;
      if (!enable) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (raw_valid) begin
                  dir_n     = raw_keycode;
                  cnt_n     = HOP_LAST;
                  keycode_n = raw_keycode;
                  state_n   = HOP;
               end
            end
            HOP: begin
               if (cnt == 8'd0) begin
                  cnt_n   = COOL_LAST;
                  state_n = COOL;
                  if (dir == KEY_W && fwd_hops != 8'hFF)
                     fwd_hops_n = fwd_hops + 8'd1;
               end else begin
                  cnt_n     = cnt - 8'd1;
                  keycode_n = dir;
               end
            end
            COOL: begin
               if (cnt == 8'd0)
                  state_n = WAIT_REL;
               else
                  cnt_n = cnt - 8'd1;
            end
            WAIT_REL: begin
               // Leaving only on a change suppresses keyboard auto-repeat.
               if (raw_keycode != dir)
                  state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign hop_active = (state == HOP);

endmodule

// File: tb/tb_frog_hop_keycode_gen.sv
// tb/tb_frog_hop_keycode_gen.sv - directed vector checks for frog_hop_keycode_gen
// Vector table covers the press/hold/switch/abort sequences; saturation and async reset are hand-written.

module tb_frog_hop_keycode_gen;

   logic        Reset;
   logic        frame_clk = 1'b0;
   logic        enable;
   logic [15:0] raw_keycode;
   logic [15:0] keycode;
   logic        hop_active;
   logic [7:0]  fwd_hops;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      logic        en;
      logic [15:0] raw;
      logic [15:0] key;
      logic        hop;
      logic [7:0]  fwd;
   } vec_t;

   vec_t vecs[$];

   frog_hop_keycode_gen dut (
      .Reset       (Reset),
      .frame_clk   (frame_clk),
      .enable      (enable),
      .raw_keycode (raw_keycode),
      .keycode     (keycode),
      .hop_active  (hop_active),
      .fwd_hops    (fwd_hops)
   );

   always #5 frame_clk = ~frame_clk;

   initial begin
      #400000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic rep(input int n, input logic en, input logic [15:0] raw,
                      input logic [15:0] key, input logic hop, input logic [7:0] fwd);
      vec_t v;
      v.en = en; v.raw = raw; v.key = key; v.hop = hop; v.fwd = fwd;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic en, input logic [15:0] raw);
      enable      = en;
      raw_keycode = raw;
      @(posedge frame_clk);
      #1;
   endtask

   initial begin
      int exp_fwd;
      Reset       = 1'b1;
      enable      = 1'b0;
      raw_keycode = 16'h0000;

      // press W held 20 frames: one hop, then stuck in WAIT_REL
      rep(4,  1'b1, 16'h001A, 16'h001A, 1'b1, 8'd0);
      rep(16, 1'b1, 16'h001A, 16'h0000, 1'b0, 8'd1);
      rep(1,  1'b1, 16'h0000, 16'h0000, 1'b0, 8'd1);
      // D tapped for one frame
      rep(1,  1'b1, 16'h0007, 16'h0007, 1'b1, 8'd1);
      rep(3,  1'b1, 16'h0000, 16'h0007, 1'b1, 8'd1);
      rep(4,  1'b1, 16'h0000, 16'h0000, 1'b0, 8'd1);
      // A held, switched to S mid-hop
      rep(2,  1'b1, 16'h0004, 16'h0004, 1'b1, 8'd1);
      rep(2,  1'b1, 16'h0016, 16'h0004, 1'b1, 8'd1);
      rep(4,  1'b1, 16'h0016, 16'h0000, 1'b0, 8'd1);
      rep(4,  1'b1, 16'h0016, 16'h0016, 1'b1, 8'd1);
      rep(4,  1'b1, 16'h0000, 16'h0000, 1'b0, 8'd1);
      // non-direction keys ignored
      rep(2,  1'b1, 16'h0029, 16'h0000, 1'b0, 8'd1);
      rep(2,  1'b1, 16'h0075, 16'h0000, 1'b0, 8'd1);
      rep(1,  1'b1, 16'h0000, 16'h0000, 1'b0, 8'd1);
      // W hop aborted by enable, then re-enabled with key held
      rep(2,  1'b1, 16'h001A, 16'h001A, 1'b1, 8'd1);
      rep(2,  1'b0, 16'h001A, 16'h0000, 1'b0, 8'd1);
      rep(4,  1'b1, 16'h001A, 16'h001A, 1'b1, 8'd1);
      rep(1,  1'b1, 16'h001A, 16'h0000, 1'b0, 8'd2);
      rep(3,  1'b1, 16'h0000, 16'h0000, 1'b0, 8'd2);
      // disabled in IDLE blocks a valid key
      rep(2,  1'b0, 16'h0004, 16'h0000, 1'b0, 8'd2);

      @(posedge frame_clk);
      #1;
      chk("reset_keycode", keycode, 16'h0000);
      chk("reset_hop_active", {15'd0, hop_active}, 16'h0000);
      chk("reset_fwd_hops", {8'd0, fwd_hops}, 16'h0000);
      Reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].en, vecs[i].raw);
         chk($sformatf("vec%0d_keycode", i), keycode, vecs[i].key);
         chk($sformatf("vec%0d_hop_active", i), {15'd0, hop_active}, {15'd0, vecs[i].hop});
         chk($sformatf("vec%0d_fwd_hops", i), {8'd0, fwd_hops}, {8'd0, vecs[i].fwd});
      end

      // 300 press/release W hops: counter saturates at 255
      exp_fwd = 2;
      for (int n = 0; n < 300; n++) begin
         step(1'b1, 16'h001A);
         for (int j = 0; j < 7; j++) step(1'b1, 16'h0000);
         if (exp_fwd < 255) exp_fwd++;
         chk($sformatf("sat%0d_fwd_hops", n), {8'd0, fwd_hops}, 16'(exp_fwd));
      end
      chk("sat_keycode_idle", keycode, 16'h0000);

      // async reset mid-hop clears outputs without an edge
      step(1'b1, 16'h001A);
      step(1'b1, 16'h001A);
      chk("pre_reset_keycode", keycode, 16'h001A);
      chk("pre_reset_hop_active", {15'd0, hop_active}, 16'h0001);
      #2;
      Reset = 1'b1;
      #1;
      chk("async_reset_keycode", keycode, 16'h0000);
      chk("async_reset_hop_active", {15'd0, hop_active}, 16'h0000);
      chk("async_reset_fwd_hops", {8'd0, fwd_hops}, 16'h0000);
      @(posedge frame_clk);
      #1;
      chk("held_reset_keycode", keycode, 16'h0000);
      Reset = 1'b0;
      step(1'b1, 16'h001A);
      chk("post_reset_keycode", keycode, 16'h001A);
      chk("post_reset_fwd_hops", {8'd0, fwd_hops}, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
